// File: rtl/arm_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control FSM: state codes, opcode
// classes and datapath select values used by the controller and its timer.
package arm_multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_FAULT    = 4'd11
  } state_t;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;
  localparam logic       SRCA_REG   = 1'b0;
  localparam logic       SRCA_PC    = 1'b1;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // cmd[3:2] of TST/TEQ/CMP/CMN: flags only, no register result
  localparam logic [1:0] CMD_TEST_CLASS = 2'b10;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-wait cycles; expired flags the cycle in which the
// MAX-th wait would be counted so the FSM can leave for FAULT on that edge.
module mem_wait_timer #(
  parameter int unsigned MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count <= '0;
    else if (clr)  count <= '0;
    else if (tick) count <= count + 8'd1;
  end

  assign expired = tick && (count == 8'(MAX - 1));

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Main control FSM of the multicycle ARM datapath (fetch/decode/execute/mem/wb).
// Define CTRL_PERF_EN to build the retired-instruction counter; otherwise instr_count is 0.
module arm_multicycle_ctrl
  import arm_multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic [5:0]       funct,
  input  logic [3:0]       rd,
  input  logic             cond_ex,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             flag_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             alu_op,
  output logic [1:0]       result_src,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count,
  output state_t           dbg_state
);

  state_t state, state_next;
  logic   in_mem, expired, wb_to_pc;
  logic   unused_funct;

  assign unused_funct = ^funct[2:1];
  assign in_mem       = is_mem_state(state);
  assign wb_to_pc     = (rd == 4'd15);
  assign dbg_state    = state;
  assign fault        = (state == S_FAULT);

  // A completed access also clears, so the next memory state starts from zero.
  mem_wait_timer #(.MAX(MEM_WAIT_MAX)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!in_mem || mem_ready),
    .tick    (in_mem && !mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = ADR_PC;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    flag_write = 1'b0;
    alu_src_a  = SRCA_REG;
    alu_src_b  = SRCB_REG;
    alu_op     = 1'b0;
    result_src = RES_ALUOUT;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        // mem_ready is tested first so completion beats a coincident timeout
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (expired) begin
          state_next = S_FAULT;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_FOUR;
        case (op)
          OP_DP:   state_next = funct[5] ? S_EXECI : S_EXECR;
          OP_MEM:  state_next = S_MEMADR;
          OP_BR:   state_next = S_BRANCH;
          default: state_next = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alu_src_b  = SRCB_IMM;
        state_next = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = ADR_ALUOUT;
        if (mem_ready)    state_next = S_MEMWB;
        else if (expired) state_next = S_FAULT;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = ADR_ALUOUT;
        if (mem_ready)    state_next = S_FETCH;
        else if (expired) state_next = S_FAULT;
      end
      S_EXECR, S_EXECI: begin
        alu_src_b  = (state == S_EXECI) ? SRCB_IMM : SRCB_REG;
        alu_op     = 1'b1;
        flag_write = funct[0] & cond_ex;
        state_next = (funct[4:3] == CMD_TEST_CLASS) ? S_FETCH : S_ALUWB;
      end
      S_ALUWB, S_MEMWB: begin
        result_src = (state == S_MEMWB) ? RES_READDATA : RES_ALUOUT;
        pc_write   = cond_ex & wb_to_pc;
        reg_write  = cond_ex & ~wb_to_pc;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_write   = cond_ex;
        state_next = S_FETCH;
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FAULT;
    endcase
  end

`ifdef CTRL_PERF_EN
  logic             retire;
  logic [CNT_W-1:0] count_q;

  // Retire = any arrival in FETCH except the IDLE start-up and FETCH holds.
  assign retire = (state_next == S_FETCH) && (state != S_FETCH) && (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count_q <= '0;
    else if (retire) count_q <= count_q + CNT_W'(1);
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Self-checking bench for arm_multicycle_ctrl: per-cycle expected state and
// control vector pushed on drive, popped and compared at the falling edge.
module tb_arm_multicycle_ctrl;
  import arm_multicycle_ctrl_pkg::*;

  localparam int W = 18;

  logic       clk, rst_n;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       cond_ex, mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic       flag_write, alu_src_a, alu_op, fault;
  logic [1:0] alu_src_b, result_src;
  logic [3:0] instr_count;
  state_t     dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_cnt = 4'd0;

  arm_multicycle_ctrl #(.MEM_WAIT_MAX(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .rd(rd),
    .cond_ex(cond_ex), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .flag_write(flag_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .fault(fault), .instr_count(instr_count),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected controls straight from the state table.
  function automatic logic [13:0] exp_ctl(input state_t st, input logic [5:0] f,
                                          input logic [3:0] r, input logic c, input logic rdy);
    logic mreq, mwr, adr, irw, pcw, rgw, flw, sa, aop, flt;
    logic [1:0] sb, res;
    {mreq, mwr, adr, irw, pcw, rgw, flw, sa, aop, flt} = '0;
    sb = 2'b00; res = 2'b00;
    case (st)
      S_FETCH:    begin mreq = 1; sa = 1; sb = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
      S_DECODE:   begin sa = 1; sb = 2'b10; end
      S_MEMADR:   sb = 2'b01;
      S_MEMREAD:  begin mreq = 1; adr = 1; end
      S_MEMWRITE: begin mreq = 1; mwr = 1; adr = 1; end
      S_EXECR:    begin aop = 1; flw = f[0] & c; end
      S_EXECI:    begin sb = 2'b01; aop = 1; flw = f[0] & c; end
      S_ALUWB:    begin pcw = c & (r == 4'd15); rgw = c & (r != 4'd15); end
      S_MEMWB:    begin res = 2'b01; pcw = c & (r == 4'd15); rgw = c & (r != 4'd15); end
      S_BRANCH:   begin sb = 2'b01; res = 2'b10; pcw = c; end
      S_FAULT:    flt = 1;
      default:    ;
    endcase
    return {mreq, mwr, adr, irw, pcw, rgw, flw, sa, sb, aop, res, flt};
  endfunction

  function automatic logic [W-1:0] obs();
    return {dbg_state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
            flag_write, alu_src_a, alu_src_b, alu_op, result_src, fault};
  endfunction

  task automatic drive(input state_t st, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic c, input logic rdy);
    @(posedge clk); #1;
    op = o; funct = f; rd = r; cond_ex = c; mem_ready = rdy;
    exp_q.push_back({st, exp_ctl(st, f, r, c, rdy)});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    op = 2'b00; funct = 6'd0; rd = 4'd0; cond_ex = 1'b0; mem_ready = 1'b0;
    exp_q.delete();
    exp_cnt = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [W-1:0] got;
    rst_n = 1'b0;
    op = 2'b00; funct = 6'd0; rd = 4'd0; cond_ex = 1'b1; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    got = obs();
    n_checks++;
    if (got !== {S_IDLE, 14'd0}) begin
      n_fail++; $display("FAIL reset_hold got=%h exp=%h", got, {S_IDLE, 14'd0});
    end
    n_checks++;
    if (instr_count !== 4'd0) begin
      n_fail++; $display("FAIL reset_count got=%0d exp=0", instr_count);
    end
    rst_n = 1'b1;
    #1;
    got = obs();
    n_checks++;
    if (got !== {S_IDLE, 14'd0}) begin
      n_fail++; $display("FAIL reset_release got=%h exp=%h", got, {S_IDLE, 14'd0});
    end
    drive(S_FETCH, 2'b00, 6'd0, 4'd0, 1'b1, 1'b0);
    got = obs(); n_checks++;
    if (got !== exp_q.pop_front()) begin
      n_fail++; $display("FAIL reset_first_fetch got=%h", got);
    end
  endtask

  // ADD immediate (I=1) and register (I=0) forms both end in ALUWB to r1.
  task automatic test_add();
    state_t seq[5];
    logic [W-1:0] got, ev;
    logic [5:0] f;
    for (int form = 0; form < 2; form++) begin
      do_reset();
      f = (form == 0) ? 6'b101000 : 6'b001000;
      seq = '{S_FETCH, S_DECODE, (form == 0) ? S_EXECI : S_EXECR, S_ALUWB, S_FETCH};
      for (int i = 0; i < 5; i++) begin
        drive(seq[i], 2'b00, f, 4'd1, 1'b1, 1'b1);
        got = obs(); ev = exp_q.pop_front(); n_checks++;
        if (got !== ev) begin
          n_fail++; $display("FAIL add%0d cyc%0d got=%h exp=%h", form, i, got, ev);
        end
      end
    end
  endtask

  task automatic test_ldr_pc();
    state_t seq[10];
    logic   rdy[10];
    logic [W-1:0] got, ev;
    do_reset();
    seq = '{S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_MEMADR,
            S_MEMREAD, S_MEMREAD, S_MEMWB, S_FETCH};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(seq[i], 2'b01, 6'b011001, 4'd15, 1'b1, rdy[i]);
      got = obs(); ev = exp_q.pop_front(); n_checks++;
      if (got !== ev) begin
        n_fail++; $display("FAIL ldr_pc cyc%0d got=%h exp=%h", i, got, ev);
      end
    end
  endtask

  task automatic test_branch_cmp();
    state_t seq[4];
    logic [W-1:0] got, ev;
    for (int c = 0; c < 2; c++) begin
      do_reset();
      seq = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
      for (int i = 0; i < 4; i++) begin
        drive(seq[i], 2'b10, 6'b000000, 4'd0, c[0], 1'b1);
        got = obs(); ev = exp_q.pop_front(); n_checks++;
        if (got !== ev) begin
          n_fail++; $display("FAIL branch_c%0d cyc%0d got=%h exp=%h", c, i, got, ev);
        end
      end
    end
    do_reset();
    seq = '{S_FETCH, S_DECODE, S_EXECR, S_FETCH};
    for (int i = 0; i < 4; i++) begin
      drive(seq[i], 2'b00, 6'b010101, 4'd0, 1'b1, 1'b1);
      got = obs(); ev = exp_q.pop_front(); n_checks++;
      if (got !== ev) begin
        n_fail++; $display("FAIL cmp cyc%0d got=%h exp=%h", i, got, ev);
      end
    end
  endtask

  task automatic test_str_timeout();
    state_t seq[10];
    logic   rdy[10];
    logic [W-1:0] got, ev;
    do_reset();
    seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_MEMWRITE, S_MEMWRITE,
            S_MEMWRITE, S_FAULT, S_FAULT, S_FAULT};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      drive(seq[i], 2'b01, 6'b011000, 4'd2, 1'b1, rdy[i]);
      got = obs(); ev = exp_q.pop_front(); n_checks++;
      if (got !== ev) begin
        n_fail++; $display("FAIL str_timeout cyc%0d got=%h exp=%h", i, got, ev);
      end
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (fault !== 1'b0 || dbg_state !== S_IDLE) begin
      n_fail++; $display("FAIL fault_clear got fault=%b state=%0d exp fault=0 state=0", fault, dbg_state);
    end
  endtask

  // Ready arriving in the would-be expiry cycle completes; then op=11 faults.
  task automatic test_ready_wins_undef();
    state_t seq[7];
    logic   rdy[7];
    logic [W-1:0] got, ev;
    do_reset();
    seq = '{S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_FAULT, S_FAULT};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(seq[i], 2'b11, 6'b000000, 4'd0, 1'b1, rdy[i]);
      got = obs(); ev = exp_q.pop_front(); n_checks++;
      if (got !== ev) begin
        n_fail++; $display("FAIL ready_wins_undef cyc%0d got=%h exp=%h", i, got, ev);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    state_t seq[4];
    logic   rdy[4];
    logic [W-1:0] got, ev;
    do_reset();
    seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(seq[i], 2'b01, 6'b011001, 4'd3, 1'b1, rdy[i]);
      got = obs(); ev = exp_q.pop_front(); n_checks++;
      if (got !== ev) begin
        n_fail++; $display("FAIL mid_reset_seq cyc%0d got=%h exp=%h", i, got, ev);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    got = obs(); n_checks++;
    if (got !== {S_IDLE, 14'd0}) begin
      n_fail++; $display("FAIL mid_reset_async got=%h exp=%h", got, {S_IDLE, 14'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(S_FETCH, 2'b01, 6'b011001, 4'd3, 1'b1, 1'b0);
    got = obs(); ev = exp_q.pop_front(); n_checks++;
    if (got !== ev) begin
      n_fail++; $display("FAIL mid_reset_refetch got=%h exp=%h", got, ev);
    end
  endtask

  task automatic test_perf_count();
    state_t seq[3];
    logic [W-1:0] got, ev;
    do_reset();
    seq = '{S_FETCH, S_DECODE, S_EXECR};
    for (int n = 0; n < 17; n++) begin
      for (int i = 0; i < 3; i++) begin
        drive(seq[i], 2'b00, 6'b010101, 4'd0, 1'b1, 1'b1);
        got = obs(); ev = exp_q.pop_front(); n_checks++;
        if (got !== ev) begin
          n_fail++; $display("FAIL perf_seq n%0d cyc%0d got=%h exp=%h", n, i, got, ev);
        end
        if (i == 0) begin
          n_checks++;
          if (instr_count !== exp_cnt) begin
            n_fail++; $display("FAIL perf_count n%0d got=%0d exp=%0d", n, instr_count, exp_cnt);
          end
        end
      end
`ifdef CTRL_PERF_EN
      exp_cnt = exp_cnt + 4'd1;
`endif
    end
    seq = '{S_FETCH, S_DECODE, S_FAULT};
    for (int i = 0; i < 3; i++) begin
      drive(seq[i], 2'b11, 6'b000000, 4'd0, 1'b1, 1'b1);
      got = obs(); ev = exp_q.pop_front(); n_checks++;
      if (got !== ev) begin
        n_fail++; $display("FAIL perf_fault cyc%0d got=%h exp=%h", i, got, ev);
      end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (instr_count !== exp_cnt) begin
      n_fail++; $display("FAIL perf_hold_in_fault got=%0d exp=%0d", instr_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr_pc();
    test_branch_cmp();
    test_str_timeout();
    test_ready_wins_undef();
    test_reset_mid_access();
    test_perf_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
